// File: rtl/node_mac_serial.sv
// Serial neuron: one MAC per accepted beat, then ReLU/round/shift/saturate; result 2 cycles after last beat, held until out_ready.
// Input is stalled (in_ready=0) while finishing and holding a result. NODE_LEAKY_RELU_EN selects a 1/8-slope negative region.
module node_mac_serial #(
    parameter int N_IN = 30,
    parameter int D_W  = 8,
    parameter int W_W  = 8,
    parameter int FRAC = 6,
    parameter logic [N_IN*W_W-1:0] WEIGHTS = '0,
    localparam int ACC_W = D_W + W_W + $clog2(N_IN) + 1,
    parameter logic signed [ACC_W-1:0] BIAS = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [D_W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] out_data,
    output logic           out_sat
);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] P_LAST = IDX_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] P_MAX = ACC_W'((1 << (D_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] P_MIN = -P_MAX - ACC_W'(1);

    typedef enum logic [1:0] {S_ACC, S_FIN, S_OUT} state_t;

    state_t                     r_state, w_state_nxt;
    logic        [IDX_W-1:0]    r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic        [W_W-1:0]      w_weight;
    logic signed [D_W+W_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_shr;
    logic signed [ACC_W-1:0]    w_rnd;
    logic        [D_W-1:0]      w_res;
    logic                       w_sat;
    logic                       w_beat;

    assign in_ready   = (r_state == S_ACC);
    assign w_beat     = in_valid && in_ready;
    assign w_weight   = WEIGHTS[r_idx*W_W +: W_W];
    assign w_prod     = $signed(in_data) * $signed(w_weight);
    assign w_prod_ext = {{(ACC_W-D_W-W_W){w_prod[D_W+W_W-1]}}, w_prod};
    // Round half up: add back the bit just below the binary point.
    assign w_shr      = r_acc >>> FRAC;
    assign w_rnd      = w_shr + {{(ACC_W-1){1'b0}}, r_acc[FRAC-1]};

`ifdef NODE_LEAKY_RELU_EN
    logic signed [ACC_W-1:0] w_leak;
`endif

    always_comb begin
        w_res = '0;
        w_sat = 1'b0;
`ifdef NODE_LEAKY_RELU_EN
        w_leak = w_rnd >>> 3;
`endif
        if (!r_acc[ACC_W-1]) begin
            if (w_rnd > P_MAX) begin
                w_res = P_MAX[D_W-1:0];
                w_sat = 1'b1;
            end else begin
                w_res = w_rnd[D_W-1:0];
            end
        end
`ifdef NODE_LEAKY_RELU_EN
        else begin
            if (w_leak < P_MIN) begin
                w_res = P_MIN[D_W-1:0];
                w_sat = 1'b1;
            end else begin
                w_res = w_leak[D_W-1:0];
            end
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACC:   if (w_beat && (r_idx == P_LAST)) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_ACC;
            default: w_state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_ACC;
            r_idx     <= '0;
            r_acc     <= BIAS;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_ACC: begin
                    if (w_beat) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_idx <= (r_idx == P_LAST) ? '0 : r_idx + IDX_W'(1);
                    end
                end
                S_FIN: begin
                    out_data  <= w_res;
                    out_sat   <= w_sat;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_acc     <= BIAS;
                        r_idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
